// File: rtl/uc_secuencial.sv
// Sequenced control unit for the 8-bit microcontroller: decodes Opcode/z into
// datapath controls and runs them through an IDLE/WAIT/EXEC/HALTED sequencer.
module uc_secuencial #(
    parameter int FETCH_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Opcode,
    input  logic        z,
    input  logic        run,
    input  logic        step,
    output logic        s_inc,
    output logic        s_inm,
    output logic        we3,
    output logic        wez,
    output logic [2:0]  Op,
    output logic        pc_we,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] icount,
    output logic [1:0]  dbg_state
);

    // Debug encoding seen on dbg_state: 0 idle, 1 wait, 2 exec, 3 halted.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam bit         HAS_WAIT  = (FETCH_WAIT > 0);
    localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(FETCH_WAIT - 1) : 4'd0;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_nxt;
    logic       single;
    logic       single_nxt;
    logic       in_exec;

    logic       dec_s_inc;
    logic       dec_s_inm;
    logic       dec_we3;
    logic       dec_wez;
    logic [2:0] dec_op;
    logic       halt_op;
    logic       illegal_op;

    // Fixed ISA decode, purely combinational from Opcode and z.
    always_comb begin
        dec_s_inc  = 1'b1;
        dec_s_inm  = 1'b0;
        dec_we3    = 1'b0;
        dec_wez    = 1'b0;
        dec_op     = 3'b000;
        halt_op    = 1'b0;
        illegal_op = 1'b0;
        casez (Opcode)
            6'b1?????: begin
                dec_op  = Opcode[4:2];
                dec_we3 = 1'b1;
                dec_wez = 1'b1;
            end
            6'b01????: begin
                dec_we3   = 1'b1;
                dec_s_inm = 1'b1;
            end
            6'b000000: dec_s_inc = 1'b0;
            6'b000001: dec_s_inc = ~z;
            6'b000010: dec_s_inc = z;
            6'b000011: dec_s_inc = 1'b1;
            6'b000100: halt_op   = 1'b1;
            default:   illegal_op = 1'b1;
        endcase
    end

    // State register plus the wait counter and single-step flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            single   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            single   <= single_nxt;
        end
    end

    // run is a level that keeps instructions flowing; step is a one-cycle
    // request honoured only in IDLE with run low, and never queued.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        single_nxt   = single;
        case (state)
            ST_IDLE: begin
                if (run || step) begin
                    single_nxt = ~run;
                    if (HAS_WAIT) begin
                        state_nxt    = ST_WAIT;
                        wait_cnt_nxt = WAIT_LOAD;
                    end else begin
                        state_nxt = ST_EXEC;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = ST_EXEC;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            ST_EXEC: begin
                if (halt_op) begin
                    state_nxt = ST_HALTED;
                end else if (single || !run) begin
                    state_nxt = ST_IDLE;
                end else if (HAS_WAIT) begin
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = WAIT_LOAD;
                end else begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign in_exec = (state == ST_EXEC);

    // Outputs hold safe values except during the single EXEC cycle.
    always_comb begin
        s_inc = 1'b1;
        s_inm = 1'b0;
        we3   = 1'b0;
        wez   = 1'b0;
        Op    = 3'b000;
        pc_we = 1'b0;
        if (in_exec) begin
            s_inc = dec_s_inc;
            s_inm = dec_s_inm;
            we3   = dec_we3;
            wez   = dec_wez;
            Op    = dec_op;
            pc_we = ~halt_op;
        end
    end

    // Retired-instruction counter and sticky illegal flag commit on EXEC edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            icount  <= 16'd0;
            illegal <= 1'b0;
        end else if (in_exec) begin
            icount <= icount + 16'd1;
            if (illegal_op) begin
                illegal <= 1'b1;
            end
        end
    end

    assign halted    = (state == ST_HALTED);
    assign dbg_state = state;

endmodule

// File: tb/tb_uc_secuencial.sv
// Randomized bench for uc_secuencial: two instances (no wait states and two
// wait states) checked against an instruction-level reference model.
module tb_uc_secuencial;

    localparam int FW_A = 0;
    localparam int FW_B = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // ---------------- stimulus (index 0 -> dut_a, 1 -> dut_b) ----------------
    logic [1:0][5:0] opc, opc_n;
    logic [1:0]      zf, zf_n, run_v, run_n, step_v, step_n;

    logic        s_inc_a, s_inm_a, we3_a, wez_a, pc_we_a, halted_a, illegal_a;
    logic [2:0]  op_a;
    logic [15:0] icount_a;
    logic [1:0]  dbg_a;
    logic        s_inc_b, s_inm_b, we3_b, wez_b, pc_we_b, halted_b, illegal_b;
    logic [2:0]  op_b;
    logic [15:0] icount_b;
    logic [1:0]  dbg_b;

    logic [7:0] ctl_a, ctl_b;
    assign ctl_a = {s_inc_a, s_inm_a, we3_a, wez_a, op_a, pc_we_a};
    assign ctl_b = {s_inc_b, s_inm_b, we3_b, wez_b, op_b, pc_we_b};

    uc_secuencial #(.FETCH_WAIT(FW_A)) dut_a (
        .clk(clk), .reset(reset), .Opcode(opc[0]), .z(zf[0]), .run(run_v[0]), .step(step_v[0]),
        .s_inc(s_inc_a), .s_inm(s_inm_a), .we3(we3_a), .wez(wez_a), .Op(op_a), .pc_we(pc_we_a),
        .halted(halted_a), .illegal(illegal_a), .icount(icount_a), .dbg_state(dbg_a)
    );

    uc_secuencial #(.FETCH_WAIT(FW_B)) dut_b (
        .clk(clk), .reset(reset), .Opcode(opc[1]), .z(zf[1]), .run(run_v[1]), .step(step_v[1]),
        .s_inc(s_inc_b), .s_inm(s_inm_b), .we3(we3_b), .wez(wez_b), .Op(op_b), .pc_we(pc_we_b),
        .halted(halted_b), .illegal(illegal_b), .icount(icount_b), .dbg_state(dbg_b)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Control word {s_inc, s_inm, we3, wez, Op[2:0], pc_we} straight from the ISA table.
    function automatic logic [7:0] exp_ctl(input logic [5:0] o, input logic zz);
        int v;
        v = int'(o);
        if (v >= 32) return {1'b1, 1'b0, 1'b1, 1'b1, o[4:2], 1'b1};
        if (v >= 16) return 8'b1110_0001;
        case (v)
            0:       return 8'b0000_0001;
            1:       return {~zz, 7'b000_0001};
            2:       return {zz, 7'b000_0001};
            4:       return 8'b1000_0000;
            default: return 8'b1000_0001;
        endcase
    endfunction

    function automatic bit is_illegal(input logic [5:0] o);
        return (int'(o) >= 5) && (int'(o) <= 15);
    endfunction

    // An instruction in flight commits after m_left more cycles; idle means none in flight.
    bit          m_idle[2];
    bit          m_single[2];
    bit          m_halted[2];
    bit          m_ill[2];
    int          m_left[2];
    logic [15:0] m_count[2];
    int          fw_tab[2];

    function automatic bit m_exec(input int d);
        return !m_idle[d] && !m_halted[d] && (m_left[d] == 0);
    endfunction

    task automatic model_reset(input int d);
        m_idle[d]   = 1'b1;
        m_single[d] = 1'b0;
        m_halted[d] = 1'b0;
        m_ill[d]    = 1'b0;
        m_left[d]   = 0;
        m_count[d]  = 16'd0;
    endtask

    task automatic model_edge(input int d);
        if (!reset) begin
            model_reset(d);
        end else if (m_halted[d]) begin
            m_halted[d] = 1'b1;
        end else if (m_idle[d]) begin
            if (run_v[d] || step_v[d]) begin
                m_idle[d]   = 1'b0;
                m_left[d]   = fw_tab[d];
                m_single[d] = !run_v[d];
            end
        end else if (m_left[d] > 0) begin
            m_left[d] = m_left[d] - 1;
        end else begin
            m_count[d] = m_count[d] + 16'd1;
            if (is_illegal(opc[d])) m_ill[d] = 1'b1;
            if (opc[d] == 6'b000100) m_halted[d] = 1'b1;
            else if (m_single[d] || !run_v[d]) m_idle[d] = 1'b1;
            else m_left[d] = fw_tab[d];
        end
    endtask

    task automatic check_dut(input int d);
        logic [7:0]  c;
        logic [15:0] ic;
        logic        h, il;
        if (d == 0) begin
            c = ctl_a; ic = icount_a; h = halted_a; il = illegal_a;
        end else begin
            c = ctl_b; ic = icount_b; h = halted_b; il = illegal_b;
        end
        check_eq($sformatf("ctl_%0d", d), 32'(c), 32'(m_exec(d) ? exp_ctl(opc[d], zf[d]) : 8'h80));
        check_eq($sformatf("icount_%0d", d), 32'(ic), 32'(m_count[d]));
        check_eq($sformatf("halted_%0d", d), 32'(h), 32'(m_halted[d]));
        check_eq($sformatf("illegal_%0d", d), 32'(il), 32'(m_ill[d]));
    endtask

    // ---------------- driver ----------------
    // One clock: model commits with the inputs the DUT sampled, then the staged
    // inputs are applied and outputs are checked on the falling edge.
    task automatic tick(input bit chk);
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        opc    = opc_n;
        zf     = zf_n;
        run_v  = run_n;
        step_v = step_n;
        @(negedge clk);
        if (chk) begin
            check_dut(0);
            check_dut(1);
        end
    endtask

    function automatic logic [5:0] rand_legal();
        case ($urandom_range(0, 3))
            0:       return {1'b1, 5'($urandom_range(0, 31))};
            1:       return {2'b01, 4'($urandom_range(0, 15))};
            default: return 6'($urandom_range(0, 3));
        endcase
    endfunction

    function automatic logic [5:0] rand_any_no_halt();
        logic [5:0] o;
        o = 6'($urandom_range(0, 63));
        if (o == 6'b000100) o = 6'b000011;
        return o;
    endfunction

    // ---------------- directed tables ----------------
    logic [5:0] prog[9] = '{6'b010110, 6'b101101, 6'b000011, 6'b000000, 6'b000001,
                            6'b000001, 6'b000010, 6'b000010, 6'b000011};
    logic       prog_z[9]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       prog_inc[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    logic [15:0] start_cnt;
    int          n_ex;
    int          budget;

    initial begin
        reset  = 1'b0;
        opc    = '0; opc_n  = '0;
        zf     = '0; zf_n   = '0;
        run_v  = '0; run_n  = '0;
        step_v = '0; step_n = '0;
        fw_tab[0] = FW_A;
        fw_tab[1] = FW_B;
        model_reset(0);
        model_reset(1);

        // Reset state
        #3;
        check_dut(0);
        check_dut(1);
        check_eq("rst_dbg_a", 32'(dbg_a), 32'd0);
        check_eq("rst_dbg_b", 32'(dbg_b), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // No wait states, run held: LI/ALU/NOP then the jump table
        run_n[0] = 1'b1;
        opc_n[0] = prog[0];
        tick(1);
        for (int i = 0; i < 9; i++) begin
            opc_n[0] = prog[i];
            zf_n[0]  = prog_z[i];
            tick(1);
            check_eq($sformatf("seq_sinc_%0d", i), 32'(s_inc_a), 32'(prog_inc[i]));
            check_eq($sformatf("seq_pcwe_%0d", i), 32'(pc_we_a), 32'd1);
            if (i == 1) check_eq("seq_alu_op", 32'(op_a), 32'd3);
            if (i < 2) check_eq($sformatf("seq_we3_%0d", i), 32'(we3_a), 32'd1);
            if (i == 3) check_eq("seq_icount3", 32'(icount_a), 32'd3);
        end
        run_n[0] = 1'b0;
        opc_n[0] = 6'b000011;
        for (int i = 0; i < 3; i++) tick(1);

        // Two wait states, run held: one commit every third cycle
        run_n[1] = 1'b1;
        n_ex = 0;
        for (int i = 0; i < 15; i++) begin
            opc_n[1] = rand_legal();
            zf_n[1]  = 1'($urandom_range(0, 1));
            tick(1);
            if (pc_we_b) n_ex++;
        end
        check_eq("fw2_exec_count", 32'(n_ex), 32'd4);
        run_n[1] = 1'b0;
        for (int i = 0; i < 5; i++) tick(1);

        // Single step with a second pulse landing in WAIT
        start_cnt = m_count[1];
        step_n[1] = 1'b1; tick(1);
        step_n[1] = 1'b0; tick(1);
        step_n[1] = 1'b1; tick(1);
        step_n[1] = 1'b0;
        for (int i = 0; i < 6; i++) tick(1);
        check_eq("step_icount", 32'(icount_b), 32'(start_cnt + 16'd1));

        // Undefined opcode behaves as NOP and sets the sticky flag
        run_n[0] = 1'b1;
        opc_n[0] = 6'b001010;
        tick(1);
        tick(1);
        check_eq("illegal_pcwe", 32'(pc_we_a), 32'd1);
        opc_n[0] = 6'b000011;
        tick(1);
        check_eq("illegal_set", 32'(illegal_a), 32'd1);
        for (int i = 0; i < 3; i++) tick(1);
        check_eq("illegal_sticky", 32'(illegal_a), 32'd1);
        run_n[0] = 1'b0;
        for (int i = 0; i < 3; i++) tick(1);

        // Random run/step/opcode mix
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 2; d++) begin
                run_n[d]  = ($urandom_range(0, 9) < 7);
                step_n[d] = ($urandom_range(0, 4) == 0);
                opc_n[d]  = rand_any_no_halt();
                zf_n[d]   = 1'($urandom_range(0, 1));
            end
            tick(1);
        end

        // Asynchronous reset in the middle of an ALU EXEC cycle
        run_n    = 2'b01;
        step_n   = 2'b00;
        opc_n[0] = 6'b100100;
        for (int i = 0; i < 3; i++) tick(1);
        check_eq("pre_reset_we3", 32'(we3_a), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("rst_async_ctl", 32'(ctl_a), 32'h80);
        check_eq("rst_async_icount", 32'(icount_a), 32'd0);
        check_eq("rst_async_illegal", 32'(illegal_a), 32'd0);
        check_eq("rst_async_dbg", 32'(dbg_a), 32'd0);
        model_reset(0);
        model_reset(1);
        #1 reset = 1'b1;
        check_eq("rst_release_idle", 32'(dbg_a), 32'd0);

        // icount wrap after 65535 commits
        opc_n[0] = 6'b000011;
        budget = 0;
        while (m_count[0] != 16'hFFFF && budget < 70000) begin
            tick(0);
            budget++;
        end
        check_eq("wrap_pre", 32'(icount_a), 32'hFFFF);
        tick(1);
        check_eq("wrap_zero", 32'(icount_a), 32'd0);

        // HALT is terminal until reset
        opc_n  = {6'b000100, 6'b000100};
        run_n  = 2'b11;
        step_n = 2'b00;
        budget = 0;
        while (!(m_halted[0] && m_halted[1]) && budget < 20) begin
            tick(1);
            budget++;
        end
        check_eq("halt_a", 32'(halted_a), 32'd1);
        check_eq("halt_b", 32'(halted_b), 32'd1);
        start_cnt = m_count[0];
        for (int i = 0; i < 30; i++) begin
            for (int d = 0; d < 2; d++) begin
                run_n[d]  = 1'($urandom_range(0, 1));
                step_n[d] = 1'($urandom_range(0, 1));
                opc_n[d]  = 6'($urandom_range(0, 63));
            end
            tick(1);
            check_eq("halt_pcwe_a", 32'(pc_we_a), 32'd0);
        end
        check_eq("halt_icount_frozen", 32'(icount_a), 32'(start_cnt));

        #2 reset = 1'b0;
        #1;
        check_eq("rst_clear_halt_a", 32'(halted_a), 32'd0);
        check_eq("rst_clear_halt_b", 32'(halted_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uc_secuencial.md
# uc_secuencial

Sequenced control unit for the 8-bit microcontroller datapath. It decodes the 6-bit `Opcode` and the registered `z` flag into the datapath controls `s_inc`, `s_inm`, `we3`, `wez` and `Op`. It adds a PC write enable, a run/single-step/halt sequencer, programmable memory wait states and a retired-instruction counter. It sits beside the datapath in the top level. The top level gates the PC register load with `pc_we`.

## Interface
- `FETCH_WAIT`, default 0: extra wait cycles before each instruction commits (legal range 0..15).
- `clk` input 1: system clock, all state changes on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `Opcode` input 6: instruction bits [15:10] from the datapath.
- `z` input 1: registered zero flag from the datapath.
- `run` input 1: level. While high, instructions execute continuously.
- `step` input 1: single-cycle pulse. Executes exactly one instruction while stopped.
- `s_inc` output 1: 1 selects PC+1, 0 selects the jump address.
- `s_inm` output 1: 1 selects the immediate for the register-file write data, 0 selects the ALU result.
- `we3` output 1: register-file write enable.
- `wez` output 1: zero-flag write enable.
- `Op` output 3: ALU operation.
- `pc_we` output 1: PC register load enable.
- `halted` output 1: high once a HALT instruction has committed.
- `illegal` output 1: sticky flag, set when an undefined opcode commits.
- `icount` output 16: count of committed instructions.

## Operation
- Opcode decode (fixed ISA):
  - 1xxxxx ALU: `Op`=Opcode[4:2], `we3`=1, `wez`=1, `s_inm`=0, `s_inc`=1.
  - 01xxxx LI: `we3`=1, `s_inm`=1, `wez`=0, `s_inc`=1.
  - 000000 J: `s_inc`=0.
  - 000001 JZ: `s_inc`=~z.
  - 000010 JNZ: `s_inc`=z.
  - 000011 NOP: `s_inc`=1, no writes.
  - 000100 HALT: no writes. `pc_we`=0, so the PC stays on the HALT instruction.
  - All other 0001xx and 001xxx opcodes: behave as NOP and set `illegal`.
- FSM states: IDLE, WAIT, EXEC, HALTED.
  - IDLE: no commits. Goes to WAIT (if FETCH_WAIT>0) or EXEC when `run`=1, or when `step`=1 with `run`=0. When the start came from `step`, this is a single-step.
  - WAIT: a 4-bit counter loads FETCH_WAIT-1 on entry and counts down. Goes to EXEC when the counter reaches 0.
  - EXEC: exactly one cycle; the decoded enables are asserted here.
    - HALT opcode: goes to HALTED.
    - Otherwise, single-step or `run`=0: goes to IDLE.
    - Otherwise: goes to WAIT, or stays in EXEC when FETCH_WAIT=0.
  - HALTED: terminal until reset. `run` and `step` are ignored.
- Outside EXEC the outputs are held at safe values: `we3`=`wez`=`pc_we`=0, `s_inc`=1, `s_inm`=0, `Op`=000.
- In EXEC, `pc_we`=1 for every opcode except HALT.
- `icount` increments by 1 on every EXEC edge, including HALT and illegal opcodes. It wraps from 0xFFFF to 0x0000.
- `illegal` is set on the EXEC edge of an undefined opcode. It clears only on reset.
- Dropping `run` never aborts an instruction. An instruction in WAIT still completes, then the FSM returns to IDLE.
- `step` is ignored outside IDLE and ignored while `run`=1. A `step` pulse that arrives while the FSM is busy is not queued.

## Timing
- Reset (`reset`=0) takes effect immediately, with no clock needed:
  - State goes to IDLE.
  - `halted`=0, `illegal`=0, `icount`=0.
  - All enables 0, `s_inc`=1, `s_inm`=0, `Op`=000.
- A reset asserted in WAIT or EXEC cancels the instruction. No write occurs.
- Decode is combinational from `Opcode`/`z`, gated by the registered state. There is no decode pipeline.
- Throughput:
  - FETCH_WAIT=0 with `run` held: one instruction per clock. EXEC starts one cycle after `run` is sampled high.
  - General case: FETCH_WAIT+1 cycles per instruction.
- `z` is sampled in the same EXEC cycle as the jump. An ALU op's flag update is visible to the next instruction.
- `halted` rises on the edge that leaves EXEC for HALTED.

## Test plan
- Reset mid-EXEC, with `run`=1 and an ALU opcode: all enables drop asynchronously, `icount`=0, and the FSM is in IDLE after release.
- FETCH_WAIT=0, `run`=1, program LI/ALU/NOP: `pc_we`=1 every cycle, `we3`=1 in the LI and ALU cycles, `Op` equals Opcode[4:2], `icount`=3 after 3 EXEC cycles.
- FETCH_WAIT=2, `run`=1: EXEC once every 3 cycles. `we3`/`pc_we` are 0 in both WAIT cycles.
- JZ with `z`=1 gives `s_inc`=0. JZ with `z`=0 gives `s_inc`=1. JNZ gives the inverse. J always gives `s_inc`=0.
- `run`=0, `step` pulse: exactly one EXEC cycle, then IDLE. A second `step` pulse during WAIT is ignored, and `icount` advances by 1 only.
- Opcode 001010 gives NOP behaviour with `illegal`=1 (sticky). HALT gives `pc_we`=0 and `halted`=1, after which `run`/`step` have no effect until reset.
- `icount` preloaded by running 65535 instructions: the next EXEC gives `icount`=0x0000.
